// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed N-digit display scanner.
// Owns the refresh prescaler, digit rotation, anti-ghost blanking at the start
// of every slot and a double-buffered, frame-synchronous digit update.
// Optional build macro: LZ_SUPPRESS_EN enables leading-zero suppression.
//
// state | meaning
// IDLE  | scanning stopped, all digits dark, cnt/idx held at 0
// BLANK | dead time at the start of a slot, anodes off
// SHOW  | digit idx driven for the remainder of the slot
module display_scan_mux #(
  parameter int N_DIGITS    = 4,
  parameter int DIGIT_W     = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          load,
  input  logic [N_DIGITS*DIGIT_W-1:0]   digits_i,
  output logic [N_DIGITS-1:0]           digit_sel,
  output logic [DIGIT_W-1:0]            nibble_o,
  output logic                          blank_o,
  output logic                          frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                        state;
  logic [CW-1:0]                 cnt;
  logic [IW-1:0]                 idx;
  logic [N_DIGITS*DIGIT_W-1:0]   pend_buf;
  logic [N_DIGITS*DIGIT_W-1:0]   frame_buf;
  logic                          pend_vld;
  logic                          frame_start;
  logic                          suppress;
  logic                          show;

  // First cycle of slot 0 is the only point where frame_buf may change.
  assign frame_start = (state == BLANK) && (idx == '0) && (cnt == '0);

  // Slot sequencing: prescaler count, blank/show phases and digit rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else if (!en) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= BLANK;
          cnt   <= '0;
          idx   <= '0;
        end
        BLANK: begin
          // BLANK_CYC < REFRESH_DIV, so the slot never ends inside the blank phase
          cnt <= cnt + CW'(1);
          if (cnt == BLANK_LAST) state <= SHOW;
        end
        SHOW: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= BLANK;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          idx   <= '0;
        end
      endcase
    end
  end

  // Double buffer: loads park in pend_buf; a load coinciding with the frame
  // start bypasses the pending slot so the newest value wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_buf  <= '0;
      frame_buf <= '0;
      pend_vld  <= 1'b0;
    end else if (frame_start) begin
      if (load) begin
        frame_buf <= digits_i;
        pend_vld  <= 1'b0;
      end else if (pend_vld) begin
        frame_buf <= pend_buf;
        pend_vld  <= 1'b0;
      end
    end else if (load) begin
      pend_buf <= digits_i;
      pend_vld <= 1'b1;
    end
  end

`ifdef LZ_SUPPRESS_EN
  // A slot above the units is dark when it and every more significant digit are zero.
  always_comb begin
    suppress = 1'b0;
    if (idx != '0) begin
      suppress = 1'b1;
      for (int k = 0; k < N_DIGITS; k++) begin
        if ((k >= int'(idx)) && (frame_buf[k*DIGIT_W +: DIGIT_W] != '0)) suppress = 1'b0;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  // Outputs are pure decodes of registered state.
  assign show       = (state == SHOW) && !suppress;
  assign digit_sel  = show ? (N_DIGITS'(1) << idx) : '0;
  assign blank_o    = !show;
  assign nibble_o   = frame_buf[int'(idx)*DIGIT_W +: DIGIT_W];
  assign frame_done = (state == SHOW) && (idx == IDX_LAST) && (cnt == CNT_LAST);

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: directed scenarios plus randomized stimulus,
// checked against a frame-time reference model through a scoreboard queue.
// Honours LZ_SUPPRESS_EN when defined for the build.
module tb_display_scan_mux;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = RD * N;

  logic clk = 1'b0;
  logic rst_n, en, load;
  logic [N*W-1:0] digits;
  logic [N-1:0] digit_sel;
  logic [W-1:0] nibble_o;
  logic blank_o, frame_done;

  display_scan_mux #(.N_DIGITS(N), .DIGIT_W(W), .REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_i(digits),
    .digit_sel(digit_sel), .nibble_o(nibble_o), .blank_o(blank_o), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] sel;
    logic [W-1:0] nib;
    logic         blank;
    logic         fd;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: scanning is "running for m_t cycles"; slot and phase follow by division.
  bit             m_run;
  int             m_t;
  logic [N*W-1:0] m_fb, m_pb;
  bit             m_pv;

  task automatic model_reset();
    m_run = 0; m_t = 0; m_fb = '0; m_pb = '0; m_pv = 0;
  endtask

  task automatic model_step();
    bit at_frame_start;
    at_frame_start = m_run && ((m_t % FRAME) == 0);
    if (load) begin
      if (at_frame_start) begin m_fb = digits; m_pv = 0; end
      else begin m_pb = digits; m_pv = 1; end
    end else if (at_frame_start && m_pv) begin
      m_fb = m_pb; m_pv = 0;
    end
    if (!en) begin m_run = 0; m_t = 0; end
    else if (!m_run) begin m_run = 1; m_t = 0; end
    else m_t++;
  endtask

  task automatic push_exp();
    exp_t e;
    int slot, phase;
    bit supp, lit;
    slot  = m_run ? (m_t / RD) % N : 0;
    phase = m_t % RD;
    supp  = 0;
`ifdef LZ_SUPPRESS_EN
    supp = (slot > 0) && ((m_fb >> (slot * W)) == 0);
`endif
    lit     = m_run && (phase >= BC) && !supp;
    e.sel   = lit ? N'(1 << slot) : '0;
    e.blank = !lit;
    e.nib   = m_fb[slot*W +: W];
    e.fd    = m_run && (slot == N - 1) && (phase == RD - 1);
    exp_q.push_back(e);
  endtask

  // One clock cycle: advance model on the edge, publish expectation, then drive new inputs.
  task automatic cyc(input logic r, input logic e, input logic l, input logic [N*W-1:0] d);
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    if (!r) model_reset();
    push_exp();
    #1;
    rst_n = r; en = e; load = l; digits = d;
  endtask

  // Monitor: compare every presented output against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (digit_sel !== e.sel || nibble_o !== e.nib || blank_o !== e.blank || frame_done !== e.fd) begin
        miscompares++;
        $display("FAIL outputs t=%0t: got sel=%b nib=%h blank=%b fd=%b, want sel=%b nib=%h blank=%b fd=%b",
                 $time, digit_sel, nibble_o, blank_o, frame_done, e.sel, e.nib, e.blank, e.fd);
      end
    end
  end

  function automatic logic [N*W-1:0] rand_digits();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = ($urandom_range(1, 0) == 0) ? W'(0) : W'($urandom);
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b1; load = 1'b1; digits = 16'hFFFF;
    model_reset();

    // reset held with en and load high
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 16'hFFFF);

    // load 1234 while idle, then scan
    cyc(1'b1, 1'b0, 1'b1, 16'h1234);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (40) cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    // mid-frame load during slot 1 must wait for the next frame
    while (!(m_run && (m_t % FRAME) == 10)) cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 1'b1, 1'b1, 16'h5678);
    repeat (70) cyc(1'b1, 1'b1, 1'b0, 16'h0000);

    // sparse values for leading-zero behaviour
    cyc(1'b1, 1'b1, 1'b1, 16'h0042);
    repeat (70) cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 1'b1, 1'b1, 16'h0000);
    repeat (70) cyc(1'b1, 1'b1, 1'b0, 16'h0000);

    // en dropped at cnt 5 of slot 2, load while idle, restart
    while (!(m_run && (m_t % FRAME) == 20)) cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 1'b1, 16'h9ABC);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (40) cyc(1'b1, 1'b1, 1'b0, 16'h0000);

    // pending load, then a fresh load exactly on the frame start
    cyc(1'b1, 1'b1, 1'b1, 16'hAAAA);
    while (!(m_run && (m_t % FRAME) == FRAME - 1)) cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 1'b1, 1'b1, 16'h0F0F);
    repeat (70) cyc(1'b1, 1'b1, 1'b0, 16'h0000);

    // en dropped on the frame_done cycle
    while (!(m_run && (m_t % FRAME) == FRAME - 2)) cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 16'h0000);

    // randomized traffic with occasional mid-slot resets
    for (int i = 0; i < 4000; i++) begin
      logic r, e, l;
      r = ($urandom_range(399, 0) != 0);
      e = ($urandom_range(49, 0) != 0);
      l = ($urandom_range(7, 0) == 0);
      cyc(r, e, l, rand_digits());
    end

    repeat (2) cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
